// File: rtl/xgmii_rx_aligner_pkg.sv
// Shared XGMII constants, alignment mode type and per-lane character helpers
// for the rx lane aligner.
package xgmii_rx_aligner_pkg;

   localparam logic [7:0]  XGMII_IDLE      = 8'h07;
   localparam logic [7:0]  XGMII_START     = 8'hFB;
   localparam logic [63:0] XGMII_IDLE_WORD = 64'h0707070707070707;
   localparam logic [7:0]  XGMII_IDLE_CTRL = 8'hFF;

   typedef enum logic [0:0] {
      MODE_NORMAL = 1'b0,
      MODE_SHIFT  = 1'b1
   } mode_e;

   function automatic logic is_start(input logic [7:0] data, input logic ctrl);
      return ctrl && (data == XGMII_START);
   endfunction

   function automatic logic is_idle(input logic [7:0] data, input logic ctrl);
      return ctrl && (data == XGMII_IDLE);
   endfunction

endpackage

// File: rtl/xgmii_rx_aligner_if.sv
// Data-path and status signals of the XGMII rx aligner; the aligner is the
// slave side, the traffic source / sink is the master side.
interface xgmii_rx_aligner_if #(
   parameter int CNT_W = 16
);
   logic             rx_clk_en_i;
   logic [63:0]      xgmii_rxd_i;
   logic [7:0]       xgmii_rxc_i;
   logic [63:0]      xgmii_rxd_o;
   logic [7:0]       xgmii_rxc_o;
   logic             lane_shift_o;
   logic [CNT_W-1:0] sof_err_cnt_o;

   modport slave (
      input  rx_clk_en_i, xgmii_rxd_i, xgmii_rxc_i,
      output xgmii_rxd_o, xgmii_rxc_o, lane_shift_o, sof_err_cnt_o
   );

   modport master (
      output rx_clk_en_i, xgmii_rxd_i, xgmii_rxc_i,
      input  xgmii_rxd_o, xgmii_rxc_o, lane_shift_o, sof_err_cnt_o
   );
endinterface

// File: rtl/xgmii_rx_aligner_lane_decode.sv
// Combinational classification of one 64-bit XGMII word: Start position and
// whether the low four lanes carry only Idle.
module xgmii_lane_decode
   import xgmii_rx_aligner_pkg::*;
(
   input  logic [63:0] rxd,
   input  logic [7:0]  rxc,
   output logic        start_l0,
   output logic        start_l4,
   output logic        start_bad,
   output logic        lo_all_idle
);
   logic [7:0] start_s;
   logic [3:0] idle_s;

   // per-lane Start / Idle flags
   always_comb begin
      start_s = 8'h00;
      idle_s  = 4'h0;
      for (int k = 0; k < 8; k++) begin
         start_s[k] = is_start(rxd[8*k +: 8], rxc[k]);
      end
      for (int k = 0; k < 4; k++) begin
         idle_s[k] = is_idle(rxd[8*k +: 8], rxc[k]);
      end
   end

   assign start_l0    = start_s[0];
   assign start_l4    = start_s[4];
   assign start_bad   = |{start_s[7:5], start_s[3:1]};
   assign lo_all_idle = &idle_s;

endmodule

// File: rtl/xgmii_rx_aligner.sv
// XGMII rx lane aligner: moves every Start to lane 0 with a fixed three-cycle
// latency and counts Start characters found in unsupported positions.
module xgmii_rx_aligner
   import xgmii_rx_aligner_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic               rx_clk,
   input  logic               rx_rst,
   xgmii_rx_aligner_if.slave  bus
);
   logic [63:0]      d1_d_r, d2_d_r, out_d_r, out_d_nxt_s;
   logic [7:0]       d1_c_r, d2_c_r, out_c_r, out_c_nxt_s;
   mode_e            mode_r, mode_nxt_s;
   logic             lane_shift_r, shift_now_s, err_s;
   logic [CNT_W-1:0] cnt_r;

   logic d1_start_l0_s, d1_start_l4_s, d1_start_bad_s, d1_lo_idle_s;
   logic d2_start_l0_s, d2_start_l4_s, d2_start_bad_s, d2_lo_idle_s;
   logic dec_unused_s;

   xgmii_lane_decode u_dec_d1 (
      .rxd(d1_d_r), .rxc(d1_c_r),
      .start_l0(d1_start_l0_s), .start_l4(d1_start_l4_s),
      .start_bad(d1_start_bad_s), .lo_all_idle(d1_lo_idle_s)
   );

   xgmii_lane_decode u_dec_d2 (
      .rxd(d2_d_r), .rxc(d2_c_r),
      .start_l0(d2_start_l0_s), .start_l4(d2_start_l4_s),
      .start_bad(d2_start_bad_s), .lo_all_idle(d2_lo_idle_s)
   );

   assign dec_unused_s = ^{d1_start_l4_s, d1_start_bad_s, d1_lo_idle_s, d2_start_l0_s};

   // output word selection and next alignment mode
   always_comb begin
      shift_now_s = 1'b0;
      err_s       = d2_start_bad_s;
      mode_nxt_s  = mode_r;
      out_d_nxt_s = d2_d_r;
      out_c_nxt_s = d2_c_r;
      if (mode_r == MODE_SHIFT) begin
         shift_now_s = 1'b1;
      end else if (d2_start_l4_s) begin
         shift_now_s = 1'b1;
         // lanes 0-3 of d2 are deleted, so they must have been pure IPG
         if (!d2_lo_idle_s) begin
            err_s = 1'b1;
         end else begin
            err_s = d2_start_bad_s;
         end
      end else begin
         shift_now_s = 1'b0;
      end
      if (shift_now_s) begin
         out_d_nxt_s = {d1_d_r[31:0], d2_d_r[63:32]};
         out_c_nxt_s = {d1_c_r[3:0], d2_c_r[7:4]};
         // a lane-0 Start in d1 is emitted next cycle by NORMAL mode instead
         if (d1_start_l0_s) begin
            out_d_nxt_s[63:32] = XGMII_IDLE_WORD[63:32];
            out_c_nxt_s[7:4]   = XGMII_IDLE_CTRL[7:4];
            mode_nxt_s         = MODE_NORMAL;
         end else begin
            mode_nxt_s = MODE_SHIFT;
         end
      end else begin
         mode_nxt_s = mode_r;
      end
   end

   // pipeline, mode and saturating error counter, all frozen while disabled
   always_ff @(posedge rx_clk) begin
      if (rx_rst) begin
         d1_d_r       <= XGMII_IDLE_WORD;
         d1_c_r       <= XGMII_IDLE_CTRL;
         d2_d_r       <= XGMII_IDLE_WORD;
         d2_c_r       <= XGMII_IDLE_CTRL;
         out_d_r      <= XGMII_IDLE_WORD;
         out_c_r      <= XGMII_IDLE_CTRL;
         mode_r       <= MODE_NORMAL;
         lane_shift_r <= 1'b0;
         cnt_r        <= {CNT_W{1'b0}};
      end else if (bus.rx_clk_en_i) begin
         d1_d_r       <= bus.xgmii_rxd_i;
         d1_c_r       <= bus.xgmii_rxc_i;
         d2_d_r       <= d1_d_r;
         d2_c_r       <= d1_c_r;
         out_d_r      <= out_d_nxt_s;
         out_c_r      <= out_c_nxt_s;
         mode_r       <= mode_nxt_s;
         lane_shift_r <= shift_now_s;
         if (err_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign bus.xgmii_rxd_o   = out_d_r;
   assign bus.xgmii_rxc_o   = out_c_r;
   assign bus.lane_shift_o  = lane_shift_r;
   assign bus.sof_err_cnt_o = cnt_r;

endmodule

// File: tb/tb_xgmii_rx_aligner.sv
// Randomised self-checking bench for xgmii_rx_aligner against a lane-level
// reference model of the Start alignment rules.
module tb_xgmii_rx_aligner;
   localparam int MAXW = 256;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   xgmii_rx_aligner_if #(.CNT_W(16)) bus ();
   xgmii_rx_aligner #(.CNT_W(16)) dut (.rx_clk(clk), .rx_rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;
   int hold_err = 0;
   int nw = 0;
   logic [8:0]  bq[$];
   logic [63:0] wd[MAXW], od[MAXW], ed[MAXW];
   logic [7:0]  wc[MAXW], oc[MAXW], ec[MAXW];
   logic        ols[MAXW], els[MAXW];
   logic [15:0] ocnt[MAXW], ecnt[MAXW];

   function automatic bit lst(logic [63:0] d, logic [7:0] c, int k);
      return c[k] && (d[8*k +: 8] == 8'hFB);
   endfunction

   function automatic bit lidle(logic [63:0] d, logic [7:0] c, int k);
      return c[k] && (d[8*k +: 8] == 8'h07);
   endfunction

   task automatic add_idles(input int n);
      repeat (n) bq.push_back({1'b1, 8'h07});
   endtask

   task automatic add_frame(input int lane, input int len);
      while (bq.size() % 8 != lane) bq.push_back({1'b1, 8'h07});
      bq.push_back({1'b1, 8'hFB});
      for (int i = 0; i < len; i++) bq.push_back({1'b0, 8'($urandom_range(0, 255))});
      bq.push_back({1'b1, 8'hFD});
   endtask

   task automatic pack();
      add_idles(24);
      while (bq.size() % 8 != 0) bq.push_back({1'b1, 8'h07});
      nw = bq.size() / 8;
      for (int w = 0; w < nw; w++) begin
         for (int k = 0; k < 8; k++) begin
            wd[w][8*k +: 8] = bq[w*8+k][7:0];
            wc[w][k]        = bq[w*8+k][8];
         end
      end
      bq.delete();
   endtask

   // Word seen by the aligner's pipeline: two reset Idle words precede the stream.
   task automatic seq_word(input int e, output logic [63:0] d, output logic [7:0] c);
      if (e < 2 || e - 2 >= nw) begin
         d = 64'h0707070707070707;
         c = 8'hFF;
      end else begin
         d = wd[e-2];
         c = wc[e-2];
      end
   endtask

   task automatic model_run();
      bit shifting = 1'b0;
      int errs = 0;
      for (int e = 0; e < nw; e++) begin
         logic [63:0] lo_d, hi_d, o_d;
         logic [7:0]  lo_c, hi_c, o_c;
         bit shift_now, err;
         seq_word(e, lo_d, lo_c);
         seq_word(e + 1, hi_d, hi_c);
         shift_now = shifting || lst(lo_d, lo_c, 4);
         err = 1'b0;
         for (int k = 1; k < 8; k++) if (k != 4 && lst(lo_d, lo_c, k)) err = 1'b1;
         if (!shifting && lst(lo_d, lo_c, 4))
            for (int k = 0; k < 4; k++) if (!lidle(lo_d, lo_c, k)) err = 1'b1;
         o_d = lo_d;
         o_c = lo_c;
         if (shift_now) begin
            for (int k = 0; k < 4; k++) begin
               o_d[8*k +: 8] = lo_d[8*(k+4) +: 8];
               o_c[k]        = lo_c[k+4];
               if (lst(hi_d, hi_c, 0)) begin
                  o_d[8*(k+4) +: 8] = 8'h07;
                  o_c[k+4]          = 1'b1;
               end else begin
                  o_d[8*(k+4) +: 8] = hi_d[8*k +: 8];
                  o_c[k+4]          = hi_c[k];
               end
            end
            shifting = !lst(hi_d, hi_c, 0);
         end
         if (err && errs < 65535) errs++;
         ed[e] = o_d;  ec[e] = o_c;  els[e] = shift_now;  ecnt[e] = 16'(errs);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.rx_clk_en_i = 1'b1;
      bus.xgmii_rxd_i = 64'h0707070707070707;
      bus.xgmii_rxc_i = 8'hFF;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic run_stream(input int n, input bit gaps);
      for (int e = 0; e < n; e++) begin
         bus.rx_clk_en_i = 1'b1;
         bus.xgmii_rxd_i = wd[e];
         bus.xgmii_rxc_i = wc[e];
         @(posedge clk); #1;
         od[e] = bus.xgmii_rxd_o;  oc[e] = bus.xgmii_rxc_o;
         ols[e] = bus.lane_shift_o;  ocnt[e] = bus.sof_err_cnt_o;
         if (gaps) begin
            bus.rx_clk_en_i = 1'b0;
            bus.xgmii_rxd_i = {$urandom, $urandom};
            bus.xgmii_rxc_i = 8'($urandom);
            @(posedge clk); #1;
            if (bus.xgmii_rxd_o !== od[e] || bus.xgmii_rxc_o !== oc[e] ||
                bus.lane_shift_o !== ols[e] || bus.sof_err_cnt_o !== ocnt[e]) hold_err++;
         end
      end
      bus.rx_clk_en_i = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (bus.xgmii_rxd_o !== 64'h0707070707070707) begin
         errors++; $display("FAIL reset_rxd got=%h exp=0707070707070707", bus.xgmii_rxd_o);
      end
      checks++;
      if (bus.xgmii_rxc_o !== 8'hFF) begin
         errors++; $display("FAIL reset_rxc got=%h exp=ff", bus.xgmii_rxc_o);
      end
      checks++;
      if (bus.lane_shift_o !== 1'b0) begin
         errors++; $display("FAIL reset_shift got=%b exp=0", bus.lane_shift_o);
      end
      checks++;
      if (bus.sof_err_cnt_o !== 16'h0000) begin
         errors++; $display("FAIL reset_cnt got=%0d exp=0", bus.sof_err_cnt_o);
      end
   endtask

   task automatic test_lane0();
      do_reset();
      add_idles(16); add_frame(0, 62); pack();
      run_stream(nw, 1'b0);
      for (int e = 2; e < nw; e++) begin
         checks++;
         if (od[e] !== wd[e-2] || oc[e] !== wc[e-2] || ols[e] !== 1'b0) begin
            errors++;
            $display("FAIL lane0_passthru e=%0d got=%h/%h/%b exp=%h/%h/0", e, od[e], oc[e], ols[e], wd[e-2], wc[e-2]);
         end
      end
      checks++;
      if (ocnt[nw-1] !== 16'd0) begin
         errors++; $display("FAIL lane0_cnt got=%0d exp=0", ocnt[nw-1]);
      end
   endtask

   task automatic test_lane4();
      int k4 = -1;
      int t_in = -1;
      int t_out = -1;
      do_reset();
      add_idles(16); add_frame(4, 50); pack();
      model_run();
      run_stream(nw, 1'b0);
      for (int e = 0; e < nw; e++) begin
         checks++;
         if (od[e] !== ed[e] || oc[e] !== ec[e] || ols[e] !== els[e] || ocnt[e] !== ecnt[e]) begin
            errors++;
            $display("FAIL lane4_model e=%0d got=%h/%h/%b/%0d exp=%h/%h/%b/%0d",
                     e, od[e], oc[e], ols[e], ocnt[e], ed[e], ec[e], els[e], ecnt[e]);
         end
      end
      for (int w = 0; w < nw; w++) if (k4 < 0 && lst(wd[w], wc[w], 4)) k4 = w;
      for (int w = 0; w < nw; w++)
         for (int k = 0; k < 8; k++) if (t_in < 0 && wc[w][k] && wd[w][8*k +: 8] == 8'hFD) t_in = w*8 + k;
      for (int e = 2; e < nw; e++)
         for (int k = 0; k < 8; k++) if (t_out < 0 && oc[e][k] && od[e][8*k +: 8] == 8'hFD) t_out = (e-2)*8 + k;
      checks++;
      if (k4 < 0 || od[k4+2] !== {wd[k4+1][31:0], wd[k4][63:32]} || !lst(od[k4+2], oc[k4+2], 0) || ols[k4+2] !== 1'b1) begin
         errors++;
         $display("FAIL lane4_first_word got=%h shift=%b exp=%h shift=1", od[k4+2], ols[k4+2], {wd[k4+1][31:0], wd[k4][63:32]});
      end
      checks++;
      if (t_out !== t_in - 4) begin
         errors++; $display("FAIL lane4_term_pos got=%0d exp=%0d", t_out, t_in - 4);
      end
      checks++;
      if (ocnt[nw-1] !== 16'd0) begin
         errors++; $display("FAIL lane4_cnt got=%0d exp=0", ocnt[nw-1]);
      end
   endtask

   task automatic test_transition();
      int n_start = 0;
      int n_bad = 0;
      int tw = -1;
      do_reset();
      add_idles(16); add_frame(4, 62); add_idles(12); add_frame(0, 40); pack();
      model_run();
      run_stream(nw, 1'b0);
      for (int e = 0; e < nw; e++) begin
         checks++;
         if (od[e] !== ed[e] || oc[e] !== ec[e] || ols[e] !== els[e] || ocnt[e] !== ecnt[e]) begin
            errors++;
            $display("FAIL trans_model e=%0d got=%h/%h/%b/%0d exp=%h/%h/%b/%0d",
                     e, od[e], oc[e], ols[e], ocnt[e], ed[e], ec[e], els[e], ecnt[e]);
         end
         for (int k = 0; k < 8; k++) if (lst(od[e], oc[e], k)) begin
            if (k == 0) n_start++; else n_bad++;
         end
         if (e > 0 && tw < 0 && ols[e-1] === 1'b1 && ols[e] === 1'b0) tw = e - 1;
      end
      checks++;
      if (n_start != 2 || n_bad != 0) begin
         errors++; $display("FAIL trans_starts got=%0d/%0d exp=2/0", n_start, n_bad);
      end
      checks++;
      if (tw < 0 || od[tw][63:32] !== 32'h07070707 || oc[tw][7:4] !== 4'hF) begin
         errors++; $display("FAIL trans_idle_fill word=%0d got=%h", tw, (tw < 0) ? 64'h0 : od[tw]);
      end
   endtask

   task automatic test_enable_gaps();
      do_reset();
      hold_err = 0;
      model_run();
      run_stream(nw, 1'b1);
      for (int e = 0; e < nw; e++) begin
         checks++;
         if (od[e] !== ed[e] || oc[e] !== ec[e] || ols[e] !== els[e] || ocnt[e] !== ecnt[e]) begin
            errors++;
            $display("FAIL gaps_model e=%0d got=%h/%h/%b/%0d exp=%h/%h/%b/%0d",
                     e, od[e], oc[e], ols[e], ocnt[e], ed[e], ec[e], els[e], ecnt[e]);
         end
      end
      checks++;
      if (hold_err != 0) begin
         errors++; $display("FAIL gaps_hold got=%0d changes exp=0", hold_err);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 4; it++) begin
         do_reset();
         add_idles(8);
         for (int f = 0; f < 6; f++) begin
            int sel = $urandom_range(0, 5);
            int lane = (sel < 3) ? 0 : (sel < 5) ? 4 : 1 + 4 * $urandom_range(0, 1) + $urandom_range(0, 2);
            add_idles($urandom_range(0, 16));
            add_frame(lane, $urandom_range(8, 90));
         end
         pack();
         model_run();
         run_stream(nw, it[0]);
         for (int e = 0; e < nw; e++) begin
            checks++;
            if (od[e] !== ed[e] || oc[e] !== ec[e] || ols[e] !== els[e] || ocnt[e] !== ecnt[e]) begin
               errors++;
               $display("FAIL random_model it=%0d e=%0d got=%h/%h/%b/%0d exp=%h/%h/%b/%0d",
                        it, e, od[e], oc[e], ols[e], ocnt[e], ed[e], ec[e], els[e], ecnt[e]);
            end
         end
      end
   endtask

   task automatic test_counter();
      int k2 = -1;
      do_reset();
      add_idles(8); add_frame(2, 20); pack();
      run_stream(nw, 1'b0);
      for (int w = 0; w < nw; w++) if (k2 < 0 && lst(wd[w], wc[w], 2)) k2 = w;
      checks++;
      if (k2 < 0 || od[k2+2] !== wd[k2] || oc[k2+2] !== wc[k2]) begin
         errors++; $display("FAIL cnt_passthru got=%h exp=%h", od[k2+2], wd[k2]);
      end
      checks++;
      if (ocnt[nw-1] !== 16'd1) begin
         errors++; $display("FAIL cnt_one got=%0d exp=1", ocnt[nw-1]);
      end
      bus.rx_clk_en_i = 1'b1;
      bus.xgmii_rxc_i = 8'hFF;
      bus.xgmii_rxd_i = 64'h07070707_07FB0707;
      repeat (65540) @(posedge clk);
      #1;
      bus.xgmii_rxd_i = 64'h0707070707070707;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (bus.sof_err_cnt_o !== 16'hFFFF) begin
         errors++; $display("FAIL cnt_saturate got=%h exp=ffff", bus.sof_err_cnt_o);
      end
   endtask

   task automatic test_reset_midframe();
      int k4 = -1;
      int part;
      do_reset();
      add_idles(8); add_frame(2, 10); add_idles(6); add_frame(4, 40); pack();
      for (int w = 0; w < nw; w++) if (k4 < 0 && lst(wd[w], wc[w], 4)) k4 = w;
      part = k4 + 4;
      model_run();
      run_stream(part, 1'b0);
      for (int e = 0; e < part; e++) begin
         checks++;
         if (od[e] !== ed[e] || oc[e] !== ec[e] || ols[e] !== els[e] || ocnt[e] !== ecnt[e]) begin
            errors++;
            $display("FAIL midrst_pre e=%0d got=%h/%h/%b/%0d exp=%h/%h/%b/%0d",
                     e, od[e], oc[e], ols[e], ocnt[e], ed[e], ec[e], els[e], ecnt[e]);
         end
      end
      rst = 1'b1;
      bus.xgmii_rxd_i = {$urandom, $urandom};
      bus.xgmii_rxc_i = 8'($urandom);
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (bus.xgmii_rxd_o !== 64'h0707070707070707 || bus.xgmii_rxc_o !== 8'hFF ||
          bus.lane_shift_o !== 1'b0 || bus.sof_err_cnt_o !== 16'h0000) begin
         errors++;
         $display("FAIL midrst_state got=%h/%h/%b/%0d exp=0707070707070707/ff/0/0",
                  bus.xgmii_rxd_o, bus.xgmii_rxc_o, bus.lane_shift_o, bus.sof_err_cnt_o);
      end
      add_idles(8); add_frame(4, 30); pack();
      model_run();
      run_stream(nw, 1'b0);
      for (int e = 0; e < nw; e++) begin
         checks++;
         if (od[e] !== ed[e] || oc[e] !== ec[e] || ols[e] !== els[e] || ocnt[e] !== ecnt[e]) begin
            errors++;
            $display("FAIL midrst_post e=%0d got=%h/%h/%b/%0d exp=%h/%h/%b/%0d",
                     e, od[e], oc[e], ols[e], ocnt[e], ed[e], ec[e], els[e], ecnt[e]);
         end
      end
   endtask

   initial begin
      bus.rx_clk_en_i = 1'b1;
      bus.xgmii_rxd_i = 64'h0707070707070707;
      bus.xgmii_rxc_i = 8'hFF;
      test_reset();
      test_lane0();
      test_lane4();
      test_enable_gaps();
      test_transition();
      test_random();
      test_reset_midframe();
      test_counter();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20000000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
